// File: rtl/me_min_sad_tracker.sv
// me_min_sad_tracker: follows a raster-ordered stream of candidate SADs for
// one current block. It keeps the smallest SAD and the motion vector where
// that SAD occurred. When the whole search window has been scanned, it
// publishes min_sad, mv_x and mv_y together with a one-cycle finish_a_cur pulse.
//
// Optional build macro: ME_ZERO_MV_PRIORITY_EN
//   When this macro is defined, the zero vector (0,0) wins ties.
//   Its SAD only has to be less than or equal to the current best to replace it.
//   When the macro is undefined, only a strictly lower SAD replaces the best,
//   so the first minimum in raster order wins.
//
// Reset is asynchronous and active-low. The reset port is named rst.
module me_min_sad_tracker #(
    parameter int SAD_W    = 14,
    parameter int MV_W     = 4,
    parameter int SEARCH_W = 16,
    parameter int SEARCH_H = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sad_valid,
    input  logic [SAD_W-1:0] sad_in,
    output logic             busy,
    output logic [SAD_W-1:0] min_sad,
    output logic [MV_W-1:0]  mv_x,
    output logic [MV_W-1:0]  mv_y,
    output logic             finish_a_cur
);

    // Corners of the search window, expressed as MV_W-bit signed offsets.
    localparam logic signed [MV_W-1:0] X_MIN = MV_W'(-(SEARCH_W / 2));
    localparam logic signed [MV_W-1:0] X_MAX = MV_W'(SEARCH_W / 2 - 1);
    localparam logic signed [MV_W-1:0] Y_MIN = MV_W'(-(SEARCH_H / 2));
    localparam logic signed [MV_W-1:0] Y_MAX = MV_W'(SEARCH_H / 2 - 1);
    localparam logic signed [MV_W-1:0] ONE   = MV_W'(1);
    localparam logic [SAD_W-1:0]       SAD_INIT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic signed [MV_W-1:0] cx_reg, cx_next;
    logic signed [MV_W-1:0] cy_reg, cy_next;
    logic [SAD_W-1:0]       best_sad_reg, best_sad_next;
    logic signed [MV_W-1:0] best_x_reg, best_x_next;
    logic signed [MV_W-1:0] best_y_reg, best_y_next;

    logic [SAD_W-1:0]       min_sad_reg;
    logic signed [MV_W-1:0] mv_x_reg;
    logic signed [MV_W-1:0] mv_y_reg;
    logic                   busy_reg;
    logic                   finish_reg;

    // Search context for this cycle. A start pulse replaces it with a fresh
    // search, so a sad_valid in the same cycle is treated as the first candidate.
    logic                   active;
    logic                   take;
    logic                   better;
    logic                   last;
    logic signed [MV_W-1:0] base_x, base_y, base_bx, base_by;
    logic [SAD_W-1:0]       base_sad;
    logic [SAD_W-1:0]       cand_sad;
    logic signed [MV_W-1:0] cand_x, cand_y;

    // Compare the candidate, advance the raster counters and pick the next state.
    always_comb begin
        active   = start || (state_reg == SCAN);
        base_x   = start ? X_MIN    : cx_reg;
        base_y   = start ? Y_MIN    : cy_reg;
        base_sad = start ? SAD_INIT : best_sad_reg;
        base_bx  = start ? X_MIN    : best_x_reg;
        base_by  = start ? Y_MIN    : best_y_reg;
        take     = sad_valid && active;
`ifdef ME_ZERO_MV_PRIORITY_EN
        better   = take && ((sad_in < base_sad) ||
                            ((base_x == '0) && (base_y == '0) && (sad_in <= base_sad)));
`else
        better   = take && (sad_in < base_sad);
`endif
        cand_sad = better ? sad_in : base_sad;
        cand_x   = better ? base_x : base_bx;
        cand_y   = better ? base_y : base_by;
        last     = take && (base_x == X_MAX) && (base_y == Y_MAX);

        state_next    = state_reg;
        cx_next       = cx_reg;
        cy_next       = cy_reg;
        best_sad_next = best_sad_reg;
        best_x_next   = best_x_reg;
        best_y_next   = best_y_reg;

        case (state_reg)
            IDLE:    state_next = start ? SCAN : IDLE;
            SCAN:    state_next = SCAN;
            DONE:    state_next = start ? SCAN : IDLE;
            default: state_next = IDLE;
        endcase

        if (active) begin
            best_sad_next = cand_sad;
            best_x_next   = cand_x;
            best_y_next   = cand_y;
            cx_next       = base_x;
            cy_next       = base_y;
            if (take) begin
                if (last) begin
                    cx_next    = X_MIN;
                    cy_next    = Y_MIN;
                    state_next = DONE;
                end else if (base_x == X_MAX) begin
                    cx_next = X_MIN;
                    cy_next = base_y + ONE;
                end else begin
                    cx_next = base_x + ONE;
                end
            end
        end
    end

    // State, counters and shadow best registers. Results are loaded only on the
    // last candidate, so they stay stable while a later block is being scanned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            cx_reg       <= '0;
            cy_reg       <= '0;
            best_sad_reg <= '0;
            best_x_reg   <= '0;
            best_y_reg   <= '0;
            min_sad_reg  <= '0;
            mv_x_reg     <= '0;
            mv_y_reg     <= '0;
            busy_reg     <= 1'b0;
            finish_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cx_reg       <= cx_next;
            cy_reg       <= cy_next;
            best_sad_reg <= best_sad_next;
            best_x_reg   <= best_x_next;
            best_y_reg   <= best_y_next;
            busy_reg     <= (state_next == SCAN);
            finish_reg   <= last;
            if (last) begin
                min_sad_reg <= cand_sad;
                mv_x_reg    <= cand_x;
                mv_y_reg    <= cand_y;
            end
        end
    end

    assign busy         = busy_reg;
    assign finish_a_cur = finish_reg;
    assign min_sad      = min_sad_reg;
    assign mv_x         = mv_x_reg;
    assign mv_y         = mv_y_reg;

endmodule

// File: tb/tb_me_min_sad_tracker.sv
// tb_me_min_sad_tracker: directed scenarios for me_min_sad_tracker.
// The stimulus pushes hand-computed results into a queue. A negedge monitor
// pops one result per finish pulse. Between pulses, the monitor checks that
// the published outputs hold. It also checks busy and finish_a_cur every cycle.
module tb_me_min_sad_tracker;

    localparam int SAD_W = 14;
    localparam int MV_W  = 4;

    typedef struct packed {
        logic [SAD_W-1:0] sad;
        logic [MV_W-1:0]  x;
        logic [MV_W-1:0]  y;
    } result_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             sad_valid;
    logic [SAD_W-1:0] sad_in;
    logic             busy;
    logic [SAD_W-1:0] min_sad;
    logic [MV_W-1:0]  mv_x;
    logic [MV_W-1:0]  mv_y;
    logic             finish_a_cur;

    logic [SAD_W-1:0] sads [256];
    result_t          exp_q [$];
    result_t          held;
    logic             exp_busy;
    logic             exp_fin;
    int               checks   = 0;
    int               failures = 0;

    me_min_sad_tracker #(
        .SAD_W(SAD_W), .MV_W(MV_W), .SEARCH_W(16), .SEARCH_H(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .sad_valid(sad_valid),
        .sad_in(sad_in), .busy(busy), .min_sad(min_sad), .mv_x(mv_x),
        .mv_y(mv_y), .finish_a_cur(finish_a_cur)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: reset values, per-cycle busy/finish, scoreboard pops and output hold.
    always @(negedge clk) begin
        if (!rst) begin
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_finish", 32'(finish_a_cur), 32'd0);
            check("rst_min_sad", 32'(min_sad), 32'd0);
            check("rst_mv_x", 32'(mv_x), 32'd0);
            check("rst_mv_y", 32'(mv_y), 32'd0);
            held = '0;
        end else begin
            check("busy", 32'(busy), 32'(exp_busy));
            check("finish_a_cur", 32'(finish_a_cur), 32'(exp_fin));
            if (finish_a_cur) begin
                $display("finish: min_sad=%0d mv_x=%0d mv_y=%0d", min_sad,
                         $signed(mv_x), $signed(mv_y));
                if (exp_q.size() == 0) begin
                    check("unexpected_finish", 32'd1, 32'd0);
                end else begin
                    held = exp_q.pop_front();
                end
            end
            check("min_sad", 32'(min_sad), 32'(held.sad));
            check("mv_x", 32'(mv_x), 32'(held.x));
            check("mv_y", 32'(mv_y), 32'(held.y));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        exp_fin = 1'b0;
    endtask

    task automatic idle(input int n);
        start     = 1'b0;
        sad_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic fill(input int base, input int step);
        for (int i = 0; i < 256; i++) sads[i] = SAD_W'(base + (i * step) % 200);
    endtask

    // Start a search, then send n candidates from sads[], optionally with random gaps.
    task automatic run_search(input int n, input bit stalls);
        start     = 1'b1;
        sad_valid = 1'b0;
        tick();
        start    = 1'b0;
        exp_busy = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (stalls) begin
                for (int g = 0; g < 5 && $urandom_range(99, 0) < 40; g++) begin
                    sad_valid = 1'b0;
                    tick();
                end
            end
            sad_valid = 1'b1;
            sad_in    = sads[i];
            tick();
        end
        sad_valid = 1'b0;
        if (n == 256) begin
            exp_busy = 1'b0;
            exp_fin  = 1'b1;
        end
    endtask

    initial begin
        start     = 1'b0;
        sad_valid = 1'b0;
        sad_in    = '0;
        exp_busy  = 1'b0;
        exp_fin   = 1'b0;
        held      = '0;
        rst       = 1'b1;
        #1 rst    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        idle(2);

        // Single minimum 12 at raster index 37 -> (-3,-6)
        fill(1000, 0);
        sads[37] = 14'd12;
        exp_q.push_back('{sad: 14'd12, x: 4'hD, y: 4'hA});
        run_search(256, 1'b0);

        // Back-to-back: start lands in the DONE cycle; all-equal tie search
        fill(500, 0);
`ifdef ME_ZERO_MV_PRIORITY_EN
        exp_q.push_back('{sad: 14'd500, x: 4'h0, y: 4'h0});
`else
        exp_q.push_back('{sad: 14'd500, x: 4'h8, y: 4'h8});
`endif
        run_search(256, 1'b0);
        idle(3);

        // Stalled stream, minimum 0 at the very last candidate (7,7)
        fill(100, 37);
        sads[255] = 14'd0;
        exp_q.push_back('{sad: 14'd0, x: 4'h7, y: 4'h7});
        run_search(256, 1'b1);
        idle(4);

        // Abort after 100 candidates (one holds a smaller SAD), then a full search
        fill(300, 0);
        sads[10] = 14'd1;
        run_search(100, 1'b0);
        fill(300, 3);
        sads[154] = 14'd5;
        exp_q.push_back('{sad: 14'd5, x: 4'h2, y: 4'h1});
        run_search(256, 1'b0);
        idle(3);

        // Reset at candidate 150, then sad_valid without start must be ignored
        fill(700, 0);
        run_search(150, 1'b0);
        rst      = 1'b0;
        exp_busy = 1'b0;
        tick();
        rst       = 1'b1;
        sad_valid = 1'b1;
        sad_in    = 14'd3;
        repeat (20) tick();
        idle(2);

        // Recovery search after the reset
        fill(1000, 0);
        sads[37] = 14'd12;
        exp_q.push_back('{sad: 14'd12, x: 4'hD, y: 4'hA});
        run_search(256, 1'b0);
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
